// File: rtl/wb_block_copy_master.sv
// Wishbone classic block-copy initiator: reads one 32-bit word, writes it to the
// destination range, and repeats for the commanded word count.
module wb_block_copy_master #(
  parameter int ADDR_W         = 32,
  parameter int LEN_W          = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [LEN_W-1:0]  words_done_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [3:0]        wbm_sel_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [31:0]       wbm_dat_o,
  input  logic [31:0]       wbm_dat_i,
  input  logic              wbm_ack_i
);

  typedef enum logic [2:0] {IDLE, RD, RD_GAP, WR, WR_GAP, FIN} state_t;

  localparam logic [31:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] src_q, dst_q, offset;
  logic [LEN_W-1:0]  len_q, words_q;
  logic [31:0]       data_q;
  logic [31:0]       tmo_cnt;
  logic              err_q;
  logic              req, accept, tmo_hit;

  assign req     = (state == RD) || (state == WR);
  assign accept  = (state == IDLE) && start_i && (len_i != '0);
  assign tmo_hit = (TIMEOUT_CYCLES > 0) && req && !wbm_ack_i && (tmo_cnt == TMO_LAST);
  assign offset  = ADDR_W'({words_q, 2'b00});

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = (len_i != '0) ? RD : FIN;
      RD:      if (wbm_ack_i) state_nxt = RD_GAP;
               else if (tmo_hit) state_nxt = FIN;
      RD_GAP:  state_nxt = WR;
      WR:      if (wbm_ack_i) state_nxt = WR_GAP;
               else if (tmo_hit) state_nxt = FIN;
      WR_GAP:  state_nxt = (words_q == len_q) ? FIN : RD;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus strobes decode straight from the state register, so an async reset
  // drops them without waiting for a clock edge.
  always_comb begin
    wbm_cyc_o = req;
    wbm_stb_o = req;
    wbm_we_o  = (state == WR);
    wbm_sel_o = req ? 4'b1111 : 4'b0000;
    wbm_adr_o = '0;
    if (state == RD) wbm_adr_o = src_q + offset;
    if (state == WR) wbm_adr_o = dst_q + offset;
    busy_o = (state == RD) || (state == RD_GAP) || (state == WR) || (state == WR_GAP);
    done_o = (state == FIN);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      words_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      if (accept) begin
        src_q   <= src_addr_i;
        dst_q   <= dst_addr_i;
        len_q   <= len_i;
        words_q <= '0;
        err_q   <= 1'b0;
      end
      if ((state == RD) && wbm_ack_i) data_q <= wbm_dat_i;
      if ((state == WR) && wbm_ack_i) words_q <= words_q + 1'b1;
      if (tmo_hit) err_q <= 1'b1;
      // Counter sits at zero outside a request, so every RD/WR entry starts fresh.
      if (!req)            tmo_cnt <= '0;
      else if (!wbm_ack_i) tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign wbm_dat_o    = data_q;
  assign err_o        = err_q;
  assign words_done_o = words_q;

endmodule

// File: doc/wb_block_copy_master.md
Name: wb_block_copy_master

Overview:
- Wishbone classic initiator: copies a block of 32-bit words from a source address range to a destination address range, one read then one write per word.
- Drives the accelerator's Wishbone slave port. Uses: preloading operand matrices, setting operation/status registers, and draining results back to system memory without CPU intervention.
- Controlled by a simple start/length command interface. Reports busy, done, error and progress.

Parameters:
- ADDR_W, 32, Wishbone address width.
- LEN_W, 16, width of the word-count field.
- TIMEOUT_CYCLES, 256, cycles to wait for ack before aborting; 0 disables the timeout.

Ports:
- wb_clk_i  input  1  single clock for all logic.
- wb_rst_i  input  1  reset, asynchronous assert, active-low (0 = reset).
- start_i  input  1  one-cycle command strobe; sampled only in IDLE.
- src_addr_i  input  ADDR_W  byte address of the first source word.
- dst_addr_i  input  ADDR_W  byte address of the first destination word.
- len_i  input  LEN_W  number of 32-bit words to copy.
- busy_o  output  1  high from accepted start until done.
- done_o  output  1  one-cycle pulse when a transfer ends (success or error).
- err_o  output  1  sticky timeout flag; cleared by the next accepted start.
- words_done_o  output  LEN_W  count of words fully written.
- wbm_cyc_o  output  1  Wishbone cycle.
- wbm_stb_o  output  1  Wishbone strobe.
- wbm_we_o  output  1  1 = write.
- wbm_sel_o  output  4  byte selects; always 4'b1111 while stb is high, else 0.
- wbm_adr_o  output  ADDR_W  address.
- wbm_dat_o  output  32  write data.
- wbm_dat_i  input  32  read data.
- wbm_ack_i  input  1  slave acknowledge.

Behaviour:
- Reset (async, wb_rst_i=0): all outputs 0, including words_done_o, err_o and the internal data latch. FSM goes to IDLE.
  - Mid-transfer reset drops cyc/stb immediately, without waiting for the clock.
- States: IDLE, RD, RD_GAP, WR, WR_GAP, FIN.
- IDLE:
  - start_i=1 and len_i≠0: latch src/dst/len, clear err_o and words_done_o, set busy_o, go to RD.
  - start_i=1 and len_i=0: pulse done_o next cycle, no bus activity, busy_o stays 0.
- RD:
  - cyc=stb=1, we=0, adr = src + 4·words_done.
  - Hold all signals stable until wbm_ack_i=1.
  - On the ack edge: latch wbm_dat_i, drop cyc/stb (registered, low from the next cycle), go to RD_GAP.
- RD_GAP: one idle cycle with stb=0, so the slave sees ack low before the next request. Then go to WR.
- WR:
  - cyc=stb=we=1, adr = dst + 4·words_done, dat_o = latched word.
  - On ack: drop cyc/stb, increment words_done_o, go to WR_GAP.
- WR_GAP:
  - If words_done_o == len: go to FIN.
  - Else go to RD.
- FIN: done_o=1 for exactly one cycle, busy_o→0, return to IDLE.
- Timeout:
  - A counter clears on entry to RD or WR and increments each cycle that stb=1 and ack=0.
  - Reaching TIMEOUT_CYCLES (when nonzero): drop cyc/stb, set err_o, go to FIN.
  - words_done_o keeps the count of completed writes.
- ack outside RD/WR, or during a GAP state, is ignored.
- start_i while busy is ignored; latched parameters are unchanged.
- Address arithmetic wraps modulo 2^ADDR_W. No alignment check; the low two bits pass through unchanged.
- Bus timing: minimum per word is 2 cycles of request (ack arrives on the cycle after stb) plus 2 gap cycles.
- wbm_dat_o holds its last value when not writing. Only stb/cyc qualify it.

Test Plan:
- Basic copy: len=4, src=0x3000_0008, dst=0x3000_0108, slave acks after 3 cycles. Expect:
  - 8 bus transactions alternating read/write.
  - Read addresses 0x08, 0x0C, 0x10, 0x14 (offset) and matching writes at 0x108 etc.
  - Data copied intact; words_done_o=4; one done_o pulse; err_o=0.
- Zero length: start with len=0. Expect done_o high exactly once on the next cycle, cyc_o never asserted, busy_o=0.
- Timeout: TIMEOUT_CYCLES=8, slave never acks the 2nd write. Expect:
  - stb drops after 8 cycles of wait.
  - err_o=1, words_done_o=1, one done_o pulse.
  - A following good start clears err_o.
- Async reset: assert wb_rst_i=0 mid-WR, between clock edges. Expect cyc/stb/busy low before the next edge, words_done_o=0, and a subsequent transfer that works.
- Back-to-back handshake: slave ack is a one-cycle pulse each time.
  - Expect stb low for ≥1 cycle between every pair of transactions.
  - Expect no duplicate transfers.
  - start_i pulsed while busy has no effect.
- Wrap-around: src=0xFFFF_FFFC, len=2. Expect the second read at 0x0000_0000.
